// File: rtl/mips_mem_responder.sv
// Instruction ROM / data RAM responder for the pipelined MIPS core, with a
// program-load phase and a tohost store that halts the run and latches a result.
module mips_mem_responder #(
   parameter int          IMEM_WORDS  = 256,
   parameter int          DMEM_WORDS  = 256,
   parameter logic [31:0] TOHOST_ADDR = 32'hFFFF_FFF0
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic                          prog_we,
   input  logic [$clog2(IMEM_WORDS)-1:0] prog_addr,
   input  logic [31:0]                   prog_data,
   input  logic [31:0]                   pc,
   output logic [31:0]                   instr,
   input  logic [31:0]                   aluout,
   input  logic [31:0]                   writedata,
   input  logic                          memwrite,
   output logic [31:0]                   readdata,
   output logic                          done,
   output logic [31:0]                   result,
   output logic                          fault,
   output logic [15:0]                   store_count
);

   localparam int IA = $clog2(IMEM_WORDS);
   localparam int DA = $clog2(DMEM_WORDS);

   typedef enum logic [1:0] {
      S_LOAD = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   state_t state_reg, state_next;

   logic [31:0] imem [IMEM_WORDS];
   logic [31:0] dmem [DMEM_WORDS];

   logic        done_reg;
   logic [31:0] result_reg;
   logic        fault_reg;
   logic [15:0] store_count_reg;

   logic          fetch_ok, data_ok, tohost_hit;
   logic [IA-1:0] imem_idx;
   logic [DA-1:0] dmem_idx;

   logic imem_we, dmem_we, tohost_we, fault_set;

   // Byte addresses must be word aligned and fall inside the array; upper bits
   // are checked rather than letting the index alias back into memory.
   assign fetch_ok   = (pc[1:0] == 2'b00) && (pc[31:IA+2] == '0);
   assign data_ok    = (aluout[1:0] == 2'b00) && (aluout[31:DA+2] == '0);
   assign tohost_hit = (aluout == TOHOST_ADDR);
   assign imem_idx   = pc[IA+1:2];
   assign dmem_idx   = aluout[DA+1:2];

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg <= S_LOAD;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_LOAD:  if (start) state_next = S_RUN;
         S_RUN:   if (memwrite && tohost_hit) state_next = S_HALT;
         S_HALT:  state_next = S_HALT;
         default: state_next = S_LOAD;
      endcase
   end

   always_comb begin
      instr     = 32'h0;
      readdata  = 32'h0;
      imem_we   = 1'b0;
      dmem_we   = 1'b0;
      tohost_we = 1'b0;
      fault_set = 1'b0;
      case (state_reg)
         S_LOAD: begin
            imem_we = prog_we;
         end
         S_RUN: begin
            instr     = fetch_ok ? imem[imem_idx] : 32'h0;
            fault_set = !fetch_ok;
            readdata  = data_ok ? dmem[dmem_idx] : 32'h0;
            if (memwrite) begin
               if (tohost_hit) begin
                  tohost_we = 1'b1;
               end else if (data_ok) begin
                  dmem_we = 1'b1;
               end else begin
                  fault_set = 1'b1;
               end
            end
         end
         S_HALT: begin
            // Data stays readable after halt so a host can inspect results.
            readdata = data_ok ? dmem[dmem_idx] : 32'h0;
         end
         default: ;
      endcase
   end

   // Memory contents deliberately survive reset so a program can be re-run.
   always_ff @(posedge clk) begin
      if (imem_we) imem[prog_addr] <= prog_data;
      if (dmem_we) dmem[dmem_idx] <= writedata;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         done_reg        <= 1'b0;
         result_reg      <= 32'h0;
         fault_reg       <= 1'b0;
         store_count_reg <= 16'h0;
      end else begin
         if (tohost_we) begin
            done_reg   <= 1'b1;
            result_reg <= writedata;
         end
         if (fault_set) fault_reg <= 1'b1;
         if (dmem_we && (store_count_reg != 16'hFFFF)) begin
            store_count_reg <= store_count_reg + 16'd1;
         end
      end
   end

   assign done        = done_reg;
   assign result      = result_reg;
   assign fault       = fault_reg;
   assign store_count = store_count_reg;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Directed bench for mips_mem_responder: load, run, stores, faults, halt,
// reset re-run.
module tb_mips_mem_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        prog_we;
   logic [7:0]  prog_addr;
   logic [31:0] prog_data;
   logic [31:0] pc;
   logic [31:0] instr;
   logic [31:0] aluout;
   logic [31:0] writedata;
   logic        memwrite;
   logic [31:0] readdata;
   logic        done;
   logic [31:0] result;
   logic        fault;
   logic [15:0] store_count;

   int total = 0;
   int bad   = 0;

   mips_mem_responder #(
      .IMEM_WORDS (256),
      .DMEM_WORDS (256),
      .TOHOST_ADDR(32'hFFFF_FFF0)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .prog_we    (prog_we),
      .prog_addr  (prog_addr),
      .prog_data  (prog_data),
      .pc         (pc),
      .instr      (instr),
      .aluout     (aluout),
      .writedata  (writedata),
      .memwrite   (memwrite),
      .readdata   (readdata),
      .done       (done),
      .result     (result),
      .fault      (fault),
      .store_count(store_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
      $display("check %s observed=%h expected=%h", tag, observed, expected);
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; prog_we = 1'b0; prog_addr = 8'd0; prog_data = 32'h0;
      pc = 32'h0; aluout = 32'h0; writedata = 32'h0; memwrite = 1'b0;
      tick();
      tick();
      check("rst_done",   {31'b0, done},  32'h0);
      check("rst_result", result,         32'h0);
      check("rst_fault",  {31'b0, fault}, 32'h0);
      check("rst_count",  {16'b0, store_count}, 32'h0);
      check("rst_instr",  instr,          32'h0);
      check("rst_rdata",  readdata,       32'h0);

      // Program load
      reset = 1'b1;
      prog_we = 1'b1; prog_addr = 8'd0; prog_data = 32'h2008_0005;
      tick();
      prog_addr = 8'd1; prog_data = 32'h2009_0007;
      tick();
      prog_we = 1'b0;
      pc = 32'h0;
      check("load_instr_nop", instr, 32'h0);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("run_fetch0", instr, 32'h2008_0005);
      pc = 32'h4;
      #1 check("run_fetch4", instr, 32'h2009_0007);

      // Stores and same-cycle read-before-write
      aluout = 32'h40; writedata = 32'h1234_5678; memwrite = 1'b1;
      tick();
      memwrite = 1'b0;
      check("st1_rdata", readdata, 32'h1234_5678);
      check("st1_count", {16'b0, store_count}, 32'h1);
      writedata = 32'hDEAD_BEEF; memwrite = 1'b1;
      #1 check("st2_old_rdata", readdata, 32'h1234_5678);
      tick();
      memwrite = 1'b0;
      check("st2_new_rdata", readdata, 32'hDEAD_BEEF);
      check("st2_count", {16'b0, store_count}, 32'h2);
      aluout = 32'h44; writedata = 32'h0000_4444; memwrite = 1'b1;
      tick();
      memwrite = 1'b0;
      check("st3_rdata", readdata, 32'h0000_4444);
      check("st3_count", {16'b0, store_count}, 32'h3);
      check("no_fault_yet", {31'b0, fault}, 32'h0);

      // Fetch fault, then execution continues
      pc = 32'h2;
      #1 check("misfetch_instr", instr, 32'h0);
      tick();
      check("misfetch_fault", {31'b0, fault}, 32'h1);
      pc = 32'h0;
      #1 check("fault_sticky", {31'b0, fault}, 32'h1);
      check("post_fault_fetch", instr, 32'h2008_0005);
      pc = 32'h400;
      #1 check("oor_fetch_instr", instr, 32'h0);
      pc = 32'h0;

      // Dropped stores: misaligned and out of range (would alias 0x40 / 0x44)
      aluout = 32'h41; writedata = 32'h5555_5555; memwrite = 1'b1;
      #1 check("misaligned_rdata", readdata, 32'h0);
      tick();
      aluout = 32'h444; writedata = 32'h6666_6666;
      #1 check("oor_rdata", readdata, 32'h0);
      tick();
      aluout = 32'h400; writedata = 32'h7777_7777;
      tick();
      memwrite = 1'b0;
      check("drop_count", {16'b0, store_count}, 32'h3);
      aluout = 32'h40;
      #1 check("drop_keep40", readdata, 32'hDEAD_BEEF);
      aluout = 32'h44;
      #1 check("drop_keep44", readdata, 32'h0000_4444);

      // tohost halt
      aluout = 32'hFFFF_FFF0; writedata = 32'h0000_000C; memwrite = 1'b1;
      tick();
      memwrite = 1'b0;
      check("halt_done",   {31'b0, done}, 32'h1);
      check("halt_result", result, 32'h0000_000C);
      check("halt_instr",  instr, 32'h0);
      check("halt_count",  {16'b0, store_count}, 32'h3);
      aluout = 32'h40; writedata = 32'h8888_8888; memwrite = 1'b1; start = 1'b1;
      tick();
      memwrite = 1'b0; start = 1'b0;
      check("halt_st_count", {16'b0, store_count}, 32'h3);
      check("halt_start_ign", instr, 32'h0);
      check("halt_done_held", {31'b0, done}, 32'h1);
      check("halt_result_held", result, 32'h0000_000C);

      // Reset mid-operation
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check("rst2_count", {16'b0, store_count}, 32'h0);
      check("rst2_fault", {31'b0, fault}, 32'h0);
      check("rst2_done",  {31'b0, done}, 32'h0);
      check("rst2_instr", instr, 32'h0);
      check("rst2_rdata", readdata, 32'h0);

      // LOAD: ignored store, program write together with start
      aluout = 32'h40; writedata = 32'h9999_9999; memwrite = 1'b1;
      prog_we = 1'b1; prog_addr = 8'd2; prog_data = 32'h2010_0003; start = 1'b1;
      tick();
      memwrite = 1'b0; prog_we = 1'b0; start = 1'b0;
      pc = 32'h8;
      #1 check("we_start_fetch", instr, 32'h2010_0003);
      pc = 32'h0;
      #1 check("rerun_fetch0", instr, 32'h2008_0005);
      check("rerun_rdata40", readdata, 32'hDEAD_BEEF);
      check("rerun_count", {16'b0, store_count}, 32'h0);

      // prog_we in RUN ignored
      prog_we = 1'b1; prog_addr = 8'd0; prog_data = 32'hFFFF_FFFF;
      tick();
      prog_we = 1'b0;
      check("run_progwe_ign", instr, 32'h2008_0005);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
